verificador_senha: RTL and testbench

VERIFICADOR_SENHA -- requirements
Module: verificador_senha

---
 rtl/verificador_senha.sv | 124 ++++++++++++
 tb/tb_verificador_senha.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/verificador_senha.sv
// Password checker for a keypad lock: verifies a 4-digit BCD entry, opens the lock for a
// fixed time and locks the keypad out after too many consecutive failures.
`timescale 1ns/1ps
module verificador_senha #(
    parameter logic [15:0] SENHA          = 16'h1234,
    parameter int unsigned T_ABERTA       = 50000,
    parameter int unsigned T_BLOQUEIO     = 500000,
    parameter int unsigned MAX_TENTATIVAS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [79:0] digitos_value,
    input  logic        digitos_valid,
    output logic        teclado_enable,
    output logic        tranca_aberta,
    output logic        erro,
    output logic        bloqueado,
    output logic [2:0]  tentativas
);

    localparam logic [79:0] TODOS_E = {20{4'hE}};
    localparam logic [79:0] TODOS_B = {20{4'hB}};
    localparam logic [63:0] PAD_F   = {16{4'hF}};
    localparam logic [2:0]  MAX_T   = 3'(MAX_TENTATIVAS);
    localparam logic [31:0] FIM_AB  = 32'(T_ABERTA - 1);
    localparam logic [31:0] FIM_BL  = 32'(T_BLOQUEIO - 1);

    typedef enum logic [2:0] {
        StOcioso,
        StVerificar,
        StErro,
        StAberta,
        StBloqueado
    } estado_t;

    estado_t     estado_q, estado_d;
    logic [79:0] digitos_q, digitos_d;
    logic [2:0]  tent_q, tent_d;
    logic [31:0] timer_q, timer_d;

    logic confirma;
    logic senha_ok;

    assign confirma = digitos_valid && (digitos_value != TODOS_E) && (digitos_value != TODOS_B);
    // Exactly four digits entered, oldest digit in the highest used slot.
    assign senha_ok = (digitos_q == {PAD_F, SENHA});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q  <= StOcioso;
            digitos_q <= '1;
            tent_q    <= '0;
            timer_q   <= '0;
        end else begin
            estado_q  <= estado_d;
            digitos_q <= digitos_d;
            tent_q    <= tent_d;
            timer_q   <= timer_d;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        digitos_d = digitos_q;
        tent_d    = tent_q;
        unique case (estado_q)
            StOcioso: begin
                if (confirma) begin
                    digitos_d = digitos_value;
                    estado_d  = StVerificar;
                end
            end
            StVerificar: begin
                if (senha_ok) begin
                    tent_d   = '0;
                    estado_d = StAberta;
                end else begin
                    tent_d   = (tent_q == MAX_T) ? tent_q : tent_q + 3'd1;
                    estado_d = StErro;
                end
            end
            StErro: begin
                estado_d = (tent_q == MAX_T) ? StBloqueado : StOcioso;
            end
            StAberta: begin
                if (timer_q == FIM_AB) estado_d = StOcioso;
            end
            StBloqueado: begin
                if (timer_q == FIM_BL) begin
                    tent_d   = '0;
                    estado_d = StOcioso;
                end
            end
            default: estado_d = StOcioso;
        endcase

        // Dwell timer restarts from zero on every state change.
        if ((estado_d == estado_q) && (estado_q == StAberta || estado_q == StBloqueado)) begin
            timer_d = timer_q + 32'd1;
        end else begin
            timer_d = '0;
        end
    end

    always_comb begin
        teclado_enable = 1'b0;
        tranca_aberta  = 1'b0;
        erro           = 1'b0;
        bloqueado      = 1'b0;
        tentativas     = tent_q;
        unique case (estado_q)
            StOcioso:    teclado_enable = 1'b1;
            StVerificar: teclado_enable = 1'b1;
            StErro: begin
                teclado_enable = 1'b1;
                erro           = 1'b1;
            end
            StAberta:    tranca_aberta = 1'b1;
            StBloqueado: bloqueado     = 1'b1;
            default:     teclado_enable = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_verificador_senha.sv
// Bench for verificador_senha: directed scenarios plus random keypad traffic checked every
// cycle against an expected-output schedule built from the lock's behaviour.
`timescale 1ns/1ps
module tb_verificador_senha;

    localparam int          TA  = 8;
    localparam int          TB  = 16;
    localparam int          MAX = 3;
    localparam logic [79:0] ALL_E = {20{4'hE}};
    localparam logic [79:0] ALL_B = {20{4'hB}};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [79:0] digitos_value = '1;
    logic        digitos_valid = 1'b0;
    logic        teclado_enable, tranca_aberta, erro, bloqueado;
    logic [2:0]  tentativas;

    verificador_senha #(
        .SENHA(16'h1234),
        .T_ABERTA(TA),
        .T_BLOQUEIO(TB),
        .MAX_TENTATIVAS(MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .digitos_value(digitos_value),
        .digitos_valid(digitos_valid),
        .teclado_enable(teclado_enable),
        .tranca_aberta(tranca_aberta),
        .erro(erro),
        .bloqueado(bloqueado),
        .tentativas(tentativas)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       idle;
        logic       en;
        logic       open;
        logic       err;
        logic       blk;
        logic [2:0] tent;
    } out_t;

    out_t exp_q;
    out_t sched[$];
    int   fails_model = 0;
    int   cnt = 0;
    int   n_total = 0;
    int   n_bad = 0;
    bit   armed = 1'b0;

    function automatic out_t mk(logic idle, logic en, logic open, logic err, logic blk, int t);
        out_t o;
        o.idle = idle; o.en = en; o.open = open; o.err = err; o.blk = blk; o.tent = 3'(t);
        return o;
    endfunction

    function automatic logic [79:0] pad(int n, logic [79:0] low);
        logic [79:0] v = '1;
        for (int i = 0; i < n; i++) v[4*i +: 4] = low[4*i +: 4];
        return v;
    endfunction

    // Whole response to one accepted confirm, as a list of per-cycle outputs.
    task automatic build(input logic [79:0] val);
        sched.push_back(mk(0, 1, 0, 0, 0, cnt));
        if (val == pad(4, 80'h1234)) begin
            cnt = 0;
            repeat (TA) sched.push_back(mk(0, 0, 1, 0, 0, 0));
        end else begin
            if (cnt < MAX) cnt++;
            sched.push_back(mk(0, 1, 0, 1, 0, cnt));
            if (cnt == MAX) begin
                repeat (TB) sched.push_back(mk(0, 0, 0, 0, 1, MAX));
                cnt = 0;
            end
        end
    endtask

    task automatic step(input logic v, input logic [79:0] val);
        digitos_valid = v;
        digitos_value = val;
        @(posedge clk);
        #1;
        if (exp_q.idle && v && val != ALL_E && val != ALL_B) build(val);
        if (sched.size() > 0) exp_q = sched.pop_front();
        else exp_q = mk(1, 1, 0, 0, 0, cnt);
        digitos_valid = 1'b0;
    endtask

    task automatic lit(input string nm, input int act, input int want);
        n_total++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, want);
        end
    endtask

    // Per-cycle comparison of every output against the schedule.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && armed) begin
                n_total++;
                if ({teclado_enable, tranca_aberta, erro, bloqueado, tentativas} !==
                    {exp_q.en, exp_q.open, exp_q.err, exp_q.blk, exp_q.tent}) begin
                    n_bad++;
                    $display("FAIL cycle_model t=%0t: got en=%b open=%b err=%b blk=%b tent=%0d expected en=%b open=%b err=%b blk=%b tent=%0d",
                             $time, teclado_enable, tranca_aberta, erro, bloqueado, tentativas,
                             exp_q.en, exp_q.open, exp_q.err, exp_q.blk, exp_q.tent);
                end
            end
        end
    end

    initial begin
        int          acc_a, acc_b;
        int          kind;
        logic [79:0] v;
        exp_q = mk(1, 1, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        lit("reset_enable", int'(teclado_enable), 1);
        lit("reset_open", int'(tranca_aberta), 0);
        lit("reset_erro", int'(erro), 0);
        lit("reset_bloq", int'(bloqueado), 0);
        lit("reset_tent", int'(tentativas), 0);
        rst = 1'b1;
        armed = 1'b1;

        // Correct entry
        step(1, pad(4, 80'h1234));
        lit("verif_not_open", int'(tranca_aberta), 0);
        lit("verif_enable", int'(teclado_enable), 1);
        acc_a = 0; acc_b = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, '1);
            acc_a += int'(tranca_aberta);
            acc_b += int'(!teclado_enable);
        end
        lit("open_cycles", acc_a, 8);
        lit("enable_low_cycles", acc_b, 8);
        lit("tent_after_ok", int'(tentativas), 0);

        // Extra digit, then missing digit
        step(1, pad(5, 80'h51234));
        step(0, '1);
        lit("extra_erro", int'(erro), 1);
        lit("extra_tent", int'(tentativas), 1);
        step(0, '1);
        lit("extra_erro_one_cycle", int'(erro), 0);
        step(1, pad(3, 80'h234));
        step(0, '1);
        lit("missing_erro", int'(erro), 1);
        lit("missing_tent", int'(tentativas), 2);
        step(0, '1);

        // Timeout and clear leave everything alone
        step(1, ALL_E);
        step(0, '1);
        lit("timeout_no_erro", int'(erro), 0);
        step(1, ALL_B);
        step(0, '1);
        lit("clear_tent", int'(tentativas), 2);
        lit("clear_enable", int'(teclado_enable), 1);

        // Third failure -> lockout, strobes ignored inside it
        step(1, pad(4, 80'h4321));
        step(0, '1);
        lit("third_erro", int'(erro), 1);
        lit("third_tent", int'(tentativas), 3);
        acc_a = 0;
        for (int i = 0; i < 20; i++) begin
            step(i < 16, pad(4, 80'h1234));
            acc_a += int'(bloqueado);
        end
        lit("lockout_cycles", acc_a, 16);
        lit("tent_after_lockout", int'(tentativas), 0);
        lit("no_open_after_lockout", int'(tranca_aberta), 0);

        // Reset in the third ABERTA cycle
        step(1, pad(4, 80'h1234));
        repeat (3) step(0, '1);
        rst = 1'b0;
        #1;
        lit("async_reset_open", int'(tranca_aberta), 0);
        lit("async_reset_enable", int'(teclado_enable), 1);
        sched.delete();
        cnt = 0;
        exp_q = mk(1, 1, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        step(1, pad(4, 80'h9999));
        step(0, '1);
        lit("post_reset_tent", int'(tentativas), 1);
        step(0, '1);

        // Recovery after two failures
        step(1, pad(4, 80'h1235));
        step(0, '1);
        step(0, '1);
        lit("recov_tent2", int'(tentativas), 2);
        step(1, pad(4, 80'h1234));
        step(0, '1);
        lit("recov_open", int'(tranca_aberta), 1);
        lit("recov_tent0", int'(tentativas), 0);
        repeat (10) step(0, '1);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            kind = $urandom_range(0, 9);
            v = '1;
            case (kind)
                0, 1, 2: v = pad(4, 80'h1234);
                3: for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
                4: v = pad(5, {56'h0, 4'($urandom_range(0, 9)), 16'h1234});
                5: v = pad(3, 80'h234);
                6: v = ALL_E;
                7: v = ALL_B;
                default: v = {$urandom, $urandom, 16'($urandom)};
            endcase
            step($urandom_range(0, 3) == 0, v);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
